alu_exec_unit: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder. It merges function decode with a handshaked execute stage of configurable width. AND/OR/ADD/SUB/SLT/NOP complete in one cycle; MUL and DIV run on an iterative shift-add / restoring-divide engine. It sits between instruction decode (aop/func/operands) and writeback, with valid/ready on both sides so multi-cycle ops can stall the pipeline.

---
 rtl/alu_exec_pkg.sv | 36 +++
 rtl/alu_func_decode.sv | 42 ++++
 rtl/alu_exec_unit.sv | 143 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared encodings for the ALU execute unit: aop/func codes, internal op
// selects and the execute FSM state type.
package alu_exec_pkg;

    localparam logic [2:0] AOP_ADD   = 3'b000;
    localparam logic [2:0] AOP_SUB   = 3'b001;
    localparam logic [2:0] AOP_RTYPE = 3'b010;
    localparam logic [2:0] AOP_AND   = 3'b011;
    localparam logic [2:0] AOP_OR    = 3'b100;
    localparam logic [2:0] AOP_SLT   = 3'b101;

    localparam logic [5:0] FUNC_NOP = 6'b000000;
    localparam logic [5:0] FUNC_AND = 6'b100000;
    localparam logic [5:0] FUNC_OR  = 6'b100010;
    localparam logic [5:0] FUNC_SUB = 6'b100100;
    localparam logic [5:0] FUNC_MUL = 6'b100101;
    localparam logic [5:0] FUNC_DIV = 6'b101010;
    localparam logic [5:0] FUNC_ADD = 6'b101011;
    localparam logic [5:0] FUNC_SLT = 6'b101111;

    localparam logic [2:0] SEL_NOP = 3'b000;
    localparam logic [2:0] SEL_AND = 3'b001;
    localparam logic [2:0] SEL_OR  = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b011;
    localparam logic [2:0] SEL_MUL = 3'b100;
    localparam logic [2:0] SEL_DIV = 3'b101;
    localparam logic [2:0] SEL_ADD = 3'b110;
    localparam logic [2:0] SEL_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational aop/func decoder; shared with the hazard unit so both agree
// on which requests are multi-cycle.
module alu_func_decode
    import alu_exec_pkg::*;
(
    input  logic [2:0] aop,
    input  logic [5:0] func,
    output logic [2:0] sel,
    output logic       illegal,
    output logic       is_multicycle
);

    always_comb begin
        sel     = SEL_NOP;
        illegal = 1'b0;
        if (aop == AOP_RTYPE) begin
            case (func)
                FUNC_NOP: sel = SEL_NOP;
                FUNC_AND: sel = SEL_AND;
                FUNC_OR:  sel = SEL_OR;
                FUNC_SUB: sel = SEL_SUB;
                FUNC_MUL: sel = SEL_MUL;
                FUNC_DIV: sel = SEL_DIV;
                FUNC_ADD: sel = SEL_ADD;
                FUNC_SLT: sel = SEL_SLT;
                default:  illegal = 1'b1;
            endcase
        end else begin
            case (aop)
                AOP_ADD: sel = SEL_ADD;
                AOP_SUB: sel = SEL_SUB;
                AOP_AND: sel = SEL_AND;
                AOP_OR:  sel = SEL_OR;
                AOP_SLT: sel = SEL_SLT;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign is_multicycle = (sel == SEL_MUL) || (sel == SEL_DIV);

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute stage: single-cycle logic/arith ops plus an iterative
// shift-add multiplier and restoring divider sharing one hi:lo register pair.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       aop,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             illegal,
    output logic             div_by_zero,
    output logic             busy
);

    state_t           state_reg, state_next;
    logic [2:0]       sel_reg;
    logic [WIDTH-1:0] b_reg, lo_reg, hi_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             illegal_reg, dbz_reg;

    logic [2:0]       dec_sel;
    logic             dec_illegal, dec_mc;
    logic             accept, b_is_zero, launch_calc, done;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    alu_func_decode u_decode (
        .aop           (aop),
        .func          (func),
        .sel           (dec_sel),
        .illegal       (dec_illegal),
        .is_multicycle (dec_mc)
    );

    assign done        = (state_reg == ST_DONE);
    assign in_ready    = (state_reg == ST_IDLE) || (done && out_ready);
    assign accept      = in_valid && in_ready;
    assign b_is_zero   = (b == '0);
    // MUL by zero is trivially zero, so only nonzero divisors need iterating.
    assign launch_calc = dec_mc && !b_is_zero;

    always_comb begin
        single_res = '0;
        case (dec_sel)
            SEL_AND: single_res = a & b;
            SEL_OR:  single_res = a | b;
            SEL_SUB: single_res = a - b;
            SEL_ADD: single_res = a + b;
            SEL_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: single_res = '0;
        endcase
    end

    // hi:lo doubles as product accumulator (MUL) or remainder:quotient (DIV).
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_reg});
    assign div_diff  = div_shift[WIDTH-1:0] - b_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = launch_calc ? ST_CALC : ST_DONE;
            ST_CALC: if (cnt_reg == CNT_W'(1)) state_next = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) state_next = launch_calc ? ST_CALC : ST_DONE;
                    else        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg     <= SEL_NOP;
            b_reg       <= '0;
            lo_reg      <= '0;
            hi_reg      <= '0;
            cnt_reg     <= '0;
            illegal_reg <= 1'b0;
            dbz_reg     <= 1'b0;
        end else if (accept) begin
            sel_reg     <= dec_sel;
            b_reg       <= b;
            illegal_reg <= dec_illegal;
            dbz_reg     <= (dec_sel == SEL_DIV) && b_is_zero;
            cnt_reg     <= launch_calc ? CNT_W'(WIDTH) : '0;
            if (launch_calc) begin
                lo_reg <= a;
                hi_reg <= '0;
            end else if (dec_sel == SEL_DIV) begin
                lo_reg <= '1;
                hi_reg <= a;
            end else begin
                lo_reg <= single_res;
                hi_reg <= '0;
            end
        end else if (state_reg == ST_CALC) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (sel_reg == SEL_MUL) begin
                hi_reg <= mul_sum[WIDTH:1];
                lo_reg <= {mul_sum[0], lo_reg[WIDTH-1:1]};
            end else begin
                hi_reg <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                lo_reg <= {lo_reg[WIDTH-2:0], div_ge};
            end
        end
    end

    assign out_valid   = done;
    assign busy        = (state_reg != ST_IDLE);
    assign result      = done ? lo_reg : '0;
    assign result_hi   = done ? hi_reg : '0;
    assign zero        = done && (lo_reg == '0);
    assign illegal     = done && illegal_reg;
    assign div_by_zero = done && dbz_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32) with hand-computed expectations.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  aop;
    logic [5:0]  func;
    logic [31:0] a, b, result, result_hi;
    logic        zero, illegal, div_by_zero, busy;

    int passed = 0;
    int total  = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aop(aop), .func(func), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .zero(zero),
        .illegal(illegal), .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic req(input logic [2:0] t_aop, input logic [5:0] t_func,
                       input logic [31:0] t_a, input logic [31:0] t_b);
        in_valid = 1'b1;
        aop = t_aop;
        func = t_func;
        a = t_a;
        b = t_b;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        aop = 3'b0; func = 6'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
        else passed++;
        total++; if (result !== 32'h0 || result_hi !== 32'h0 || zero !== 1'b0 || illegal !== 1'b0 || div_by_zero !== 1'b0)
            $display("FAIL reset_out got r=%h hi=%h z=%b il=%b dz=%b exp all 0", result, result_hi, zero, illegal, div_by_zero);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        $display("reset: rdy=%b vld=%b", in_ready, out_valid);
    endtask

    task automatic test_add;
        req(3'b010, 6'b101011, 32'd5, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 32'd12 || result_hi !== 32'd0 || zero !== 1'b0)
            $display("FAIL add got v=%b r=%0d hi=%0d z=%b exp 1 12 0 0", out_valid, result, result_hi, zero);
        else passed++;
        total++; if (in_ready !== 1'b1)
            $display("FAIL add_ready got %b exp 1", in_ready);
        else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0)
            $display("FAIL add_drop got %b exp 0", out_valid);
        else passed++;
        $display("add 5+7 -> %0d", 12);
    endtask

    task automatic test_aop;
        req(3'b001, 6'b111111, 32'd10, 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 32'd7 || illegal !== 1'b0)
            $display("FAIL aop_sub got v=%b r=%0d il=%b exp 1 7 0", out_valid, result, illegal);
        else passed++;
        @(negedge clk);
        req(3'b011, 6'b0, 32'hF0F0_1234, 32'h0FF0_FF00);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (result !== 32'h00F0_1200)
            $display("FAIL aop_and got %h exp 00f01200", result);
        else passed++;
        @(negedge clk);
        req(3'b111, 6'b101011, 32'd1, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 32'd0 || illegal !== 1'b1)
            $display("FAIL aop_illegal got v=%b r=%0d il=%b exp 1 0 1", out_valid, result, illegal);
        else passed++;
        @(negedge clk);
        $display("aop: sub 10-3, and, aop=111 illegal");
    endtask

    task automatic test_back_to_back;
        req(3'b010, 6'b100100, 32'd3, 32'd3);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1)
            $display("FAIL b2b_sub got v=%b r=%0d z=%b exp 1 0 1", out_valid, result, zero);
        else passed++;
        req(3'b010, 6'b101111, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 32'd1 || zero !== 1'b0)
            $display("FAIL b2b_slt got v=%b r=%0d z=%b exp 1 1 0", out_valid, result, zero);
        else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0)
            $display("FAIL b2b_drop got %b exp 0", out_valid);
        else passed++;
        $display("back_to_back: sub 3-3 -> 0, slt -1<1 -> 1");
    endtask

    task automatic run_multi(input string name, input logic [5:0] t_func,
                             input logic [31:0] t_a, input logic [31:0] t_b,
                             input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int edges;
        int busy_bad;
        req(3'b010, t_func, t_a, t_b);
        @(negedge clk);
        edges = 1;
        busy_bad = 0;
        while (out_valid !== 1'b1 && edges < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_bad++;
            // Stray requests during CALC must be ignored.
            in_valid = (edges < 20) ? edges[0] : 1'b0;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            edges++;
        end
        in_valid = 1'b0;
        total++; if (edges !== 33)
            $display("FAIL %s_latency got %0d edges exp 33", name, edges);
        else passed++;
        total++; if (busy_bad !== 0)
            $display("FAIL %s_busy got %0d bad cycles exp 0", name, busy_bad);
        else passed++;
        total++; if (result !== exp_lo || result_hi !== exp_hi || zero !== (exp_lo == 32'd0))
            $display("FAIL %s_value got lo=%h hi=%h z=%b exp lo=%h hi=%h", name, result, result_hi, zero, exp_lo, exp_hi);
        else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_idle got v=%b busy=%b exp 0 0", name, out_valid, busy);
        else passed++;
        $display("%s a=%h b=%h -> lo=%h hi=%h in %0d edges", name, t_a, t_b, exp_lo, exp_hi, edges);
    endtask

    task automatic test_div_zero;
        req(3'b010, 6'b101010, 32'd9, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF || result_hi !== 32'd9 || div_by_zero !== 1'b1)
            $display("FAIL div0 got v=%b r=%h hi=%0d dz=%b exp 1 ffffffff 9 1", out_valid, result, result_hi, div_by_zero);
        else passed++;
        @(negedge clk);
        total++; if (div_by_zero !== 1'b0)
            $display("FAIL div0_clear got %b exp 0", div_by_zero);
        else passed++;
        $display("div 9/0 -> ffffffff rem 9 dz");
    endtask

    task automatic test_backpressure;
        int bad;
        out_ready = 1'b0;
        req(3'b000, 6'b0, 32'd10, 32'd20);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 32'd30)
            $display("FAIL bp_first got v=%b r=%0d exp 1 30", out_valid, result);
        else passed++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || result !== 32'd30 || zero !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        total++; if (bad !== 0 || out_valid !== 1'b1)
            $display("FAIL bp_hold got %0d unstable cycles v=%b exp 0 1", bad, out_valid);
        else passed++;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1)
            $display("FAIL bp_ready got %b exp 1", in_ready);
        else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0)
            $display("FAIL bp_release got %b exp 0", out_valid);
        else passed++;
        $display("backpressure add 10+20 -> 30 held 5 cycles");
    endtask

    task automatic test_illegal;
        req(3'b010, 6'b111111, 32'd5, 32'd6);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 32'd0 || result_hi !== 32'd0 || illegal !== 1'b1 || zero !== 1'b1)
            $display("FAIL illegal got v=%b r=%0d hi=%0d il=%b z=%b exp 1 0 0 1 1", out_valid, result, result_hi, illegal, zero);
        else passed++;
        @(negedge clk);
        total++; if (illegal !== 1'b0)
            $display("FAIL illegal_clear got %b exp 0", illegal);
        else passed++;
        $display("illegal func=111111 -> nop");
    endtask

    task automatic test_reset_mid_mul;
        int seen;
        req(3'b010, 6'b100101, 32'd3, 32'd4);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0)
            $display("FAIL rst_mid got busy=%b rdy=%b v=%b r=%h exp 0 1 0 0", busy, in_ready, out_valid, result);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        total++; if (seen !== 0)
            $display("FAIL rst_discard got %0d valid cycles exp 0", seen);
        else passed++;
        req(3'b010, 6'b101011, 32'd1, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || result !== 32'd2)
            $display("FAIL rst_next_add got v=%b r=%0d exp 1 2", out_valid, result);
        else passed++;
        @(negedge clk);
        $display("reset mid-mul discarded, add 1+1 -> 2");
    endtask

    initial begin
        test_reset();
        test_add();
        test_aop();
        test_back_to_back();
        run_multi("mul", 6'b100101, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1);
        run_multi("mul2", 6'b100101, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 32'h2);
        run_multi("div", 6'b101010, 32'd100, 32'd7, 32'd14, 32'd2);
        test_div_zero();
        test_backpressure();
        test_illegal();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
